// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer around a single full_adder cell.
// Operands are latched on start and fed one bit per clock, LSB first; the sum
// bits are shifted into an accumulator and the cell carry is fed back.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output o_ovf (registered alongside the result).

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             o_ovf
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic             r_carry_q;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
`ifdef SERIAL_ADD_OVF_EN
   logic             r_ovf;
`endif

   logic             w_fa_sum;
   logic             w_fa_cout;
   logic [WIDTH-1:0] w_acc_next;

   // The one adder cell: current LSB pair plus the carry from the previous bit.
   full_adder u_fa (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_cin  (r_carry_q),
      .o_sum  (w_fa_sum),
      .o_cout (w_fa_cout)
   );

   // Accumulator after this cycle's sum bit enters at the MSB end.
   assign w_acc_next = {w_fa_sum, r_acc[WIDTH-1:1]};

   // Sequencer FSM: operand latch, per-bit shifting and result/flag registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_a_sh    <= {WIDTH{1'b0}};
         r_b_sh    <= {WIDTH{1'b0}};
         r_carry_q <= 1'b0;
         r_acc     <= {WIDTH{1'b0}};
         r_cnt     <= {CW{1'b0}};
         r_sum     <= {WIDTH{1'b0}};
         r_cout    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf     <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               // DONE accepts a new start exactly like IDLE (back-to-back)
               r_done <= 1'b0;
               if (i_start) begin
                  r_a_sh    <= i_a;
                  r_b_sh    <= i_b;
                  r_carry_q <= i_cin;
                  r_cnt     <= {CW{1'b0}};
                  r_busy    <= 1'b1;
                  r_state   <= ST_SHIFT;
               end else begin
                  r_busy    <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               // start is ignored here; operands stay as latched
               r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_acc     <= w_acc_next;
               r_carry_q <= w_fa_cout;
               r_cnt     <= r_cnt + CNT_ONE;
               if (r_cnt == CNT_LAST) begin
                  r_sum   <= w_acc_next;
                  r_cout  <= w_fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                  // carry into the MSB is the carry register during the last bit
                  r_ovf   <= r_carry_q ^ w_fa_cout;
`endif
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_state <= ST_SHIFT;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
   assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq (WIDTH=8). The driver models acceptance
// at transaction level (a start is taken once the previous op's WIDTH+1 cycle
// slot has elapsed) and queues the arithmetic result; the monitor checks
// busy/done timing and the result whenever done is expected or seen.
`timescale 1ns/1ps

module tb_serial_add_seq;
   localparam int W = 8;

   typedef struct {
      int         e0;     // edge number at which start was sampled
      int         dc;     // cycle number at which done must be seen
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   exp_t q[$];
   int   cyc = 0;
   int   next_ok = 0;
   int   checks = 0;
   int   failures = 0;

   serial_add_seq #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_a     (a),
      .i_b     (b),
      .i_cin   (cin),
      .o_busy  (busy),
      .o_done  (done),
      .o_sum   (sum),
      .o_cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .o_ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // One driven cycle; the model decides whether the DUT will accept start.
   task automatic apply(input logic st, input logic [7:0] ia, input logic [7:0] ib, input logic ic);
      int   edge_n;
      logic [8:0] full;
      exp_t e;
      @(negedge clk);
      start = st; a = ia; b = ib; cin = ic;
      edge_n = cyc + 1;
      if (st && rst_n && edge_n >= next_ok) begin
         full   = {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
         e.e0   = edge_n;
         e.dc   = edge_n + W;
         e.sum  = full[7:0];
         e.cout = full[8];
         // signed overflow: same-sign operands, result sign differs
         e.ovf  = (ia[7] == ib[7]) && (full[7] != ia[7]);
         q.push_back(e);
         next_ok = edge_n + W + 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   // Monitor: busy window, done timing and result values from the queue.
   initial begin
      logic exp_busy;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (rst_n) begin
            exp_busy = 1'b0;
            foreach (q[i]) if (cyc >= q[i].e0 && cyc < q[i].e0 + W) exp_busy = 1'b1;
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (busy && done) begin
               checks++; failures++;
               $display("FAIL busy_done_overlap at cycle %0d: got both 1 expected not both", cyc);
            end
            if (q.size() > 0 && q[0].dc < cyc) begin
               checks++; failures++;
               $display("FAIL done_missing at cycle %0d: got none expected done at %0d", cyc, q[0].dc);
               void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].dc == cyc) begin
               chk("done", {31'd0, done}, 32'd1);
               chk("sum", {24'd0, sum}, {24'd0, q[0].sum});
               chk("cout", {31'd0, cout}, {31'd0, q[0].cout});
`ifdef SERIAL_ADD_OVF_EN
               chk("ovf", {31'd0, ovf}, {31'd0, q[0].ovf});
`endif
               void'(q.pop_front());
            end else begin
               chk("done_idle", {31'd0, done}, 32'd0);
            end
         end
      end
   end

   // Stimulus: directed cases from the plan, then randomized traffic.
   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
      rst_n = 1'b1;

      apply(1'b1, 8'h3C, 8'h5A, 1'b0); idle(10);
      apply(1'b1, 8'hFF, 8'h01, 1'b0); idle(10);
      apply(1'b1, 8'hFF, 8'h01, 1'b1); idle(10);
      apply(1'b1, 8'h7F, 8'h01, 1'b0); idle(10);
      apply(1'b1, 8'h80, 8'h80, 1'b0); idle(10);

      // start mid-SHIFT must be ignored
      apply(1'b1, 8'h10, 8'h20, 1'b0); idle(3);
      apply(1'b1, 8'hAA, 8'h55, 1'b0); idle(10);

      // reset 4 cycles into an operation
      apply(1'b1, 8'hC3, 8'h77, 1'b1); idle(4);
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      next_ok = 0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_sum", {24'd0, sum}, 32'd0);
      chk("midrst_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b1, 8'h01, 8'h02, 1'b0); idle(10);

      // back-to-back with start held high: three accepted ops, 9 cycles apart
      for (int i = 0; i < 20; i++) apply(1'b1, 8'h01, 8'h01, 1'b1);
      idle(12);

      // randomized traffic; some starts land mid-SHIFT and are dropped by the model
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom));
      end

      for (int i = 0; i < 40 && q.size() > 0; i++) apply(1'b0, 8'h00, 8'h00, 1'b0);
      if (q.size() > 0) begin
         checks++; failures++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
